// File: rtl/rx_packet_composer.sv
// RX inband packetizer: strobed I/Q samples -> 256-word packets (4-word header + payload),
// ping-pong buffered and streamed to the USB-side FIFO with WR / WR_done framing.
module rx_packet_composer #(
    parameter logic [4:0] CHAN_ID     = 5'd0,
    parameter int         PKT_WORDS   = 256,
    parameter int         MAX_SAMPLES = 126
) (
    input  logic        rxclk,
    input  logic        reset,
    input  logic        rx_enable,
    input  logic        rxstrobe,
    input  logic [15:0] rx_i,
    input  logic [15:0] rx_q,
    input  logic [31:0] timestamp,
    input  logic [31:0] rssi,
    input  logic        have_space,
    input  logic        clear_status,
    output logic [15:0] usb_data,
    output logic        usb_WR,
    output logic        usb_WR_done,
    output logic [15:0] overrun_count,
    output logic [1:0]  buf_full
);
    localparam logic [7:0] K_LAST  = 8'(PKT_WORDS - 1);
    localparam logic [6:0] CNT_MAX = 7'(MAX_SAMPLES);

    typedef enum logic       {F_IDLE, F_FILL} fstate_t;
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} sstate_t;

    fstate_t fstate_q, fstate_d;
    sstate_t sstate_q, sstate_d;

    logic        en_q, fill_ptr_q, send_ptr_q, sob_q, ovr_q;
    logic [6:0]  cnt_q;
    logic [7:0]  k_q;
    logic [15:0] ovr_cnt_q;
    logic [1:0]  buf_full_q, buf_full_d;

    // Header fields live beside the RAM so the payload store is pure I/Q.
    logic [1:0][31:0] hdr_ts_q;
    logic [1:0][5:0]  hdr_r6_q;
    logic [1:0][6:0]  hdr_cnt_q;
    logic [1:0]       hdr_sob_q, hdr_eob_q, hdr_ovr_q;

    logic [31:0] mem_q [2][MAX_SAMPLES];

    logic rise, fall, stb_ok, fill_full;
    logic wr_en, start, close, close_eob, drop, send_done;
    logic [6:0] widx;
    logic [5:0] rssi6;

    assign rise      = rx_enable & ~en_q;
    assign fall      = ~rx_enable & en_q;
    assign stb_ok    = rxstrobe & rx_enable;
    assign fill_full = buf_full_q[fill_ptr_q];
    assign widx      = start ? 7'd0 : cnt_q;
    assign rssi6     = (rssi > 32'd63) ? 6'd63 : rssi[5:0];

    // Fill FSM
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) fstate_q <= F_IDLE;
        else       fstate_q <= fstate_d;
    end

    always_comb begin
        fstate_d = fstate_q;
        case (fstate_q)
            F_IDLE:  if (stb_ok && !fill_full) fstate_d = F_FILL;
            F_FILL:  if (close) fstate_d = F_IDLE;
            default: fstate_d = F_IDLE;
        endcase
    end

    always_comb begin
        wr_en     = 1'b0;
        start     = 1'b0;
        close     = 1'b0;
        close_eob = 1'b0;
        drop      = 1'b0;
        case (fstate_q)
            F_IDLE: begin
                if (stb_ok) begin
                    if (fill_full) drop = 1'b1;
                    else begin
                        start = 1'b1;
                        wr_en = 1'b1;
                    end
                end
            end
            F_FILL: begin
                if (stb_ok) begin
                    wr_en = 1'b1;
                    close = (cnt_q == CNT_MAX - 7'd1);
                end else if (fall) begin
                    close     = 1'b1;
                    close_eob = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rxclk) begin
        if (wr_en) mem_q[fill_ptr_q][widx] <= {rx_q, rx_i};
    end

    // Close of one buffer and send-complete of the other may coincide.
    always_comb begin
        buf_full_d = buf_full_q;
        if (send_done) buf_full_d[send_ptr_q] = 1'b0;
        if (close)     buf_full_d[fill_ptr_q] = 1'b1;
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            en_q       <= 1'b0;
            fill_ptr_q <= 1'b0;
            cnt_q      <= '0;
            sob_q      <= 1'b0;
            ovr_q      <= 1'b0;
            ovr_cnt_q  <= '0;
            buf_full_q <= '0;
            hdr_ts_q   <= '0;
            hdr_r6_q   <= '0;
            hdr_cnt_q  <= '0;
            hdr_sob_q  <= '0;
            hdr_eob_q  <= '0;
            hdr_ovr_q  <= '0;
        end else begin
            en_q       <= rx_enable;
            buf_full_q <= buf_full_d;
            if (close)      cnt_q <= '0;
            else if (start) cnt_q <= 7'd1;
            else if (wr_en) cnt_q <= cnt_q + 7'd1;
            if (start) begin
                hdr_ts_q[fill_ptr_q] <= timestamp;
                hdr_r6_q[fill_ptr_q] <= rssi6;
            end
            if (close) begin
                hdr_cnt_q[fill_ptr_q] <= wr_en ? cnt_q + 7'd1 : cnt_q;
                hdr_sob_q[fill_ptr_q] <= sob_q;
                hdr_eob_q[fill_ptr_q] <= close_eob;
                hdr_ovr_q[fill_ptr_q] <= ovr_q;
                fill_ptr_q            <= ~fill_ptr_q;
                sob_q                 <= 1'b0;
                ovr_q                 <= 1'b0;
            end
            if (rise) sob_q <= 1'b1;
            if (drop) ovr_q <= 1'b1;
            if (clear_status)                      ovr_cnt_q <= '0;
            else if (drop && ovr_cnt_q != 16'hFFFF) ovr_cnt_q <= ovr_cnt_q + 16'd1;
        end
    end

    // Send FSM
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            sstate_q   <= S_IDLE;
            k_q        <= '0;
            send_ptr_q <= 1'b0;
        end else begin
            sstate_q <= sstate_d;
            k_q      <= (sstate_q == S_SEND) ? k_q + 8'd1 : 8'd0;
            if (sstate_q == S_DONE) send_ptr_q <= ~send_ptr_q;
        end
    end

    always_comb begin
        sstate_d = sstate_q;
        case (sstate_q)
            S_IDLE:  if (buf_full_q[send_ptr_q] && have_space) sstate_d = S_SEND;
            S_SEND:  if (k_q == K_LAST) sstate_d = S_DONE;
            S_DONE:  sstate_d = S_IDLE;
            default: sstate_d = S_IDLE;
        endcase
    end

    logic [7:0]  koff;
    logic [6:0]  pidx;
    logic [31:0] rd;
    logic [15:0] word;

    assign koff = k_q - 8'd4;
    assign pidx = koff[7:1];
    assign rd   = mem_q[send_ptr_q][pidx];

    // Payload beyond the packet's sample count reads as zero without clearing the RAM.
    always_comb begin
        word = '0;
        case (k_q)
            8'd0: word = {7'b0, hdr_cnt_q[send_ptr_q], 2'b00};
            8'd1: word = {hdr_ovr_q[send_ptr_q], 1'b0, hdr_sob_q[send_ptr_q],
                          hdr_eob_q[send_ptr_q], 1'b0, hdr_r6_q[send_ptr_q], CHAN_ID};
            8'd2: word = hdr_ts_q[send_ptr_q][15:0];
            8'd3: word = hdr_ts_q[send_ptr_q][31:16];
            default: if (pidx < hdr_cnt_q[send_ptr_q]) word = k_q[0] ? rd[31:16] : rd[15:0];
        endcase
    end

    always_comb begin
        usb_WR      = (sstate_q == S_SEND);
        usb_WR_done = (sstate_q == S_DONE);
        send_done   = (sstate_q == S_DONE);
        usb_data    = usb_WR ? word : 16'd0;
    end

    assign overrun_count = ovr_cnt_q;
    assign buf_full      = buf_full_q;
endmodule

// File: tb/tb_rx_packet_composer.sv
// Scoreboard bench for rx_packet_composer: stimulus pushes expected packet words,
// a negedge monitor pops and compares every usb_WR word and checks WR_done framing.
module tb_rx_packet_composer;
    logic        rxclk = 1'b0;
    logic        reset, rx_enable, rxstrobe, have_space, clear_status;
    logic [15:0] rx_i, rx_q;
    logic [31:0] timestamp, rssi;
    logic [15:0] usb_data, overrun_count;
    logic        usb_WR, usb_WR_done;
    logic [1:0]  buf_full;

    rx_packet_composer #(.CHAN_ID(5'd0), .PKT_WORDS(256), .MAX_SAMPLES(126)) dut (
        .rxclk(rxclk), .reset(reset), .rx_enable(rx_enable), .rxstrobe(rxstrobe),
        .rx_i(rx_i), .rx_q(rx_q), .timestamp(timestamp), .rssi(rssi),
        .have_space(have_space), .clear_status(clear_status), .usb_data(usb_data),
        .usb_WR(usb_WR), .usb_WR_done(usb_WR_done), .overrun_count(overrun_count),
        .buf_full(buf_full)
    );

    always #5 rxclk = ~rxclk;

    int          checks = 0, errors = 0;
    int          v = 0, tsc = 0;
    int          words_seen = 0, dones = 0, exp_dones = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input int v0, input int n, input bit sob, input bit eob,
                            input bit ovr, input logic [5:0] r6, input logic [31:0] ts);
        logic [15:0] s;
        exp_q.push_back(16'(n * 4));
        exp_q.push_back({ovr, 1'b0, sob, eob, 1'b0, r6, 5'd0});
        exp_q.push_back(ts[15:0]);
        exp_q.push_back(ts[31:16]);
        for (int j = 0; j < 126; j++) begin
            if (j < n) begin
                s = 16'(v0 + j);
                exp_q.push_back(s);
                exp_q.push_back(~s);
            end else begin
                exp_q.push_back(16'd0);
                exp_q.push_back(16'd0);
            end
        end
        exp_dones++;
    endtask

    task automatic step(input bit stb);
        @(posedge rxclk); #1;
        tsc++;
        timestamp = 32'(tsc);
        rxstrobe  = stb;
        if (stb) begin
            rx_i = 16'(v);
            rx_q = ~16'(v);
            v++;
        end
    endtask

    task automatic strobes(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            repeat (period - 1) step(1'b0);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || buf_full != 2'b00 || usb_WR) && n < 3000) begin
            step(1'b0);
            n++;
        end
        step(1'b0);
        step(1'b0);
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
        end
    endtask

    always @(negedge rxclk) begin
        if (!reset) begin
            if (usb_WR) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %h expected none", usb_data);
                end else begin
                    chk($sformatf("word%0d", words_seen), 32'(usb_data), 32'(exp_q.pop_front()));
                end
                words_seen++;
            end
            if (usb_WR_done) begin
                chk("pkt_words", 32'(words_seen), 32'd256);
                words_seen = 0;
                dones++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, ts0;
        reset = 1'b1; rx_enable = 1'b0; rxstrobe = 1'b0; have_space = 1'b1;
        clear_status = 1'b0; rx_i = '0; rx_q = '0; timestamp = '0; rssi = 32'h15;
        repeat (3) @(posedge rxclk);
        #1;
        chk("rst_wr", 32'(usb_WR), 32'd0);
        chk("rst_done", 32'(usb_WR_done), 32'd0);
        chk("rst_data", 32'(usb_data), 32'd0);
        chk("rst_ovr", 32'(overrun_count), 32'd0);
        chk("rst_full", 32'(buf_full), 32'd0);
        reset = 1'b0;
        step(1'b0);

        // 1: full 126-sample packet, ts 0x1000 at first strobe
        rx_enable = 1'b1;
        step(1'b0);
        tsc = 32'h0FFF;
        push_pkt(v, 126, 1'b1, 1'b0, 1'b0, 6'd21, 32'h1000);
        strobes(126, 2);
        rx_enable = 1'b0;
        wait_drain();

        // 2: short burst closed by rx_enable falling
        rssi = 32'd63;
        rx_enable = 1'b1;
        step(1'b0);
        push_pkt(v, 10, 1'b1, 1'b1, 1'b0, 6'd63, 32'(tsc + 1));
        strobes(10, 2);
        rx_enable = 1'b0;
        wait_drain();

        // 3: no space -> two packets held, remaining 148 strobes dropped
        have_space = 1'b0;
        rssi = 32'h40;
        rx_enable = 1'b1;
        step(1'b0);
        v0 = v;
        ts0 = tsc + 1;
        push_pkt(v0, 126, 1'b1, 1'b0, 1'b0, 6'd63, 32'(ts0));
        push_pkt(v0 + 126, 126, 1'b0, 1'b0, 1'b0, 6'd63, 32'(ts0 + 252));
        strobes(400, 2);
        chk("ovr_count148", 32'(overrun_count), 32'd148);
        chk("both_full", 32'(buf_full), 32'd3);
        have_space = 1'b1;
        wait_drain();
        rssi = 32'h200;
        push_pkt(v, 10, 1'b0, 1'b1, 1'b1, 6'd63, 32'(tsc + 1));
        strobes(10, 2);
        rx_enable = 1'b0;
        wait_drain();

        // 6: clear_status zeroes the counter on the next cycle
        clear_status = 1'b1;
        step(1'b0);
        clear_status = 1'b0;
        chk("ovr_cleared", 32'(overrun_count), 32'd0);

        // 4: ten back-to-back packets while draining, sob only on the first
        rx_enable = 1'b1;
        step(1'b0);
        for (int p = 0; p < 10; p++) begin
            push_pkt(v, 126, p == 0, 1'b0, 1'b0, 6'd63, 32'(tsc + 1));
            strobes(126, 3);
        end
        rx_enable = 1'b0;
        wait_drain();
        chk("no_drops", 32'(overrun_count), 32'd0);

        // 5: reset at word 100 of a packet, then a fresh burst
        rx_enable = 1'b1;
        step(1'b0);
        push_pkt(v, 20, 1'b1, 1'b1, 1'b0, 6'd63, 32'(tsc + 1));
        strobes(20, 2);
        rx_enable = 1'b0;
        begin
            int n = 0;
            while (words_seen < 100 && n < 1000) begin
                step(1'b0);
                n++;
            end
            chk("reach_k100", 32'(words_seen), 32'd100);
        end
        reset = 1'b1;
        #1;
        chk("mid_rst_wr", 32'(usb_WR), 32'd0);
        chk("mid_rst_data", 32'(usb_data), 32'd0);
        chk("mid_rst_done", 32'(usb_WR_done), 32'd0);
        chk("mid_rst_full", 32'(buf_full), 32'd0);
        exp_q.delete();
        exp_dones--;
        words_seen = 0;
        repeat (3) step(1'b0);
        reset = 1'b0;
        repeat (2) step(1'b0);
        rx_enable = 1'b1;
        step(1'b0);
        push_pkt(v, 5, 1'b1, 1'b1, 1'b0, 6'd63, 32'(tsc + 1));
        strobes(5, 2);
        rx_enable = 1'b0;
        wait_drain();

        chk("done_pulses", 32'(dones), 32'(exp_dones));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
